// File: rtl/pipeline_mem_access_pkg.sv
// ============================================================================
// Module : pipeline_mem_access_pkg
// Brief  : Shared MEM-stage types: FSM encoding, width codes, byte-lane helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam logic MEM_WORD   = 1'b0;
    localparam logic MEM_BYTE   = 1'b1;
    localparam int   BYTE_LANES = 4;

    function automatic logic [BYTE_LANES-1:0] lane_be(input logic width, input logic [1:0] lane);
        return (width == MEM_BYTE) ? (4'b0001 << lane) : 4'b1111;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_mem_access_if.sv
// ============================================================================
// Module : pipeline_mem_access_if
// Brief  : req/ack data-bus interface between the MEM stage and memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipeline_mem_access_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [3:0]            bus_be;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_mem_access_mem_load_format.sv
// ============================================================================
// Module : mem_load_format
// Brief  : Load-data lane select with sign/zero extension for byte loads.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_load_format
    import pipeline_mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic [DATA_WIDTH-1:0] i_rdata,
    input  wire logic [1:0]            i_lane,
    input  wire logic                  i_width,
    input  wire logic                  i_sign_extend,
    output logic      [DATA_WIDTH-1:0] o_data
);

    logic [7:0] w_byte;

    always_comb begin
        w_byte = i_rdata[{i_lane, 3'b000} +: 8];
        if (i_width == MEM_WORD) begin
            o_data = i_rdata;
        end else begin
            o_data = {{(DATA_WIDTH-8){i_sign_extend & w_byte[7]}}, w_byte};
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_mem_access.sv
// ============================================================================
// Module : pipeline_mem_access
// Brief  : MEM stage: req/ack bus transaction, stall, load format, writeback.
//          Optional bus timeout fault enabled by defining MEM_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_mem_access
    import pipeline_mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  flush,
    input  wire logic [ADDR_WIDTH-1:0] pc_in,
    input  wire logic [DATA_WIDTH-1:0] inst_in,
    input  wire logic [DATA_WIDTH-1:0] alu_res_in,
    input  wire logic                  mem_width_in,
    input  wire logic                  sign_extend_in,
    input  wire logic                  mem_rw_in,
    input  wire logic                  mem_enable_in,
    input  wire logic [DATA_WIDTH-1:0] mem_write_in,
    input  wire logic                  wb_src_in,
    input  wire logic                  wb_reg_in,
    output logic      [ADDR_WIDTH-1:0] pc_out,
    output logic      [DATA_WIDTH-1:0] inst_out,
    output logic      [DATA_WIDTH-1:0] wb_data_out,
    output logic                       wb_reg_out,
    output logic                       stall_req,
    output logic                       fault_out,
    pipeline_mem_access_if.master      bus
);

    mem_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  flush_q, flush_d;
    logic                  w_start;
    logic                  w_req;
    logic                  w_fault;
    logic                  w_kill;
    logic [DATA_WIDTH-1:0] w_load;

`ifdef MEM_TIMEOUT_EN
    localparam int              CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    assign w_fault = fault_q;
`else
    assign w_fault = 1'b0;
`endif

    assign w_start = mem_enable_in & ~flush;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        flush_d = flush_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        fault_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    if (bus.bus_ack) begin
                        state_d = ST_DONE;
                        rdata_d = bus.bus_rdata;
                    end else begin
                        state_d = ST_WAIT;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ST_WAIT: begin
                // A flushed transaction still runs to completion; only its writeback dies.
                if (flush) flush_d = 1'b1;
                if (bus.bus_ack) begin
                    state_d = ST_DONE;
                    rdata_d = bus.bus_rdata;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == c_CNT_LAST) begin
                    state_d = ST_DONE;
                    rdata_d = '0;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                flush_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            flush_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            flush_q <= flush_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
`endif
        end
    end

    mem_load_format #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_format (
        .i_rdata       (rdata_q),
        .i_lane        (alu_res_in[1:0]),
        .i_width       (mem_width_in),
        .i_sign_extend (sign_extend_in),
        .o_data        (w_load)
    );

    // Request is combinational so reset removes it in the same cycle.
    assign w_req = ((state_q == ST_IDLE) & w_start | (state_q == ST_WAIT)) & ~rst;
    assign w_kill = flush | ((state_q == ST_DONE) & (flush_q | w_fault));

    assign bus.bus_req   = w_req;
    assign bus.bus_we    = w_req & mem_rw_in;
    assign bus.bus_addr  = {alu_res_in[ADDR_WIDTH-1:2], 2'b00};
    assign bus.bus_be    = lane_be(mem_width_in, alu_res_in[1:0]);
    assign bus.bus_wdata = (mem_width_in == MEM_BYTE) ? {BYTE_LANES{mem_write_in[7:0]}} : mem_write_in;

    assign stall_req   = w_req;
    assign fault_out   = w_fault & ~rst;
    assign wb_reg_out  = wb_reg_in & ~w_kill & ~rst;
    assign wb_data_out = (wb_src_in & (state_q == ST_DONE)) ? w_load : alu_res_in;
    assign pc_out      = pc_in;
    assign inst_out    = inst_in;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_mem_access.sv
// ============================================================================
// Module : tb_pipeline_mem_access
// Brief  : Scoreboard bench: directed MEM-stage instructions vs. expected results.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_mem_access;

    typedef struct {
        logic [31:0] data;
        logic        reg_en;
        logic        fault;
        int          stalls;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } bexp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] pc_in, inst_in, alu_res_in, mem_write_in;
    logic        mem_width_in, sign_extend_in, mem_rw_in, mem_enable_in, wb_src_in, wb_reg_in;
    logic [31:0] pc_out, inst_out, wb_data_out;
    logic        wb_reg_out, stall_req, fault_out;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    bexp_t       bq[$];
    logic        issue_pending = 1'b0;
    int          ack_delay = 0;
    logic [31:0] resp_data = '0;

    pipeline_mem_access_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    pipeline_mem_access #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .pc_in          (pc_in),
        .inst_in        (inst_in),
        .alu_res_in     (alu_res_in),
        .mem_width_in   (mem_width_in),
        .sign_extend_in (sign_extend_in),
        .mem_rw_in      (mem_rw_in),
        .mem_enable_in  (mem_enable_in),
        .mem_write_in   (mem_write_in),
        .wb_src_in      (wb_src_in),
        .wb_reg_in      (wb_reg_in),
        .pc_out         (pc_out),
        .inst_out       (inst_out),
        .wb_data_out    (wb_data_out),
        .wb_reg_out     (wb_reg_out),
        .stall_req      (stall_req),
        .fault_out      (fault_out),
        .bus            (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Result monitor: a non-stalled cycle while an instruction is pending is its result cycle.
    initial begin : monitor
        int   stall_cnt;
        exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst && issue_pending) begin
                if (stall_req) begin
                    stall_cnt++;
                end else if (sb.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                    issue_pending = 1'b0;
                end else begin
                    e = sb.pop_front();
                    check("wb_data_out", wb_data_out, e.data);
                    check("wb_reg_out", {31'd0, wb_reg_out}, {31'd0, e.reg_en});
                    check("fault_out", {31'd0, fault_out}, {31'd0, e.fault});
                    check("stall_cycles", stall_cnt, e.stalls);
                    stall_cnt     = 0;
                    issue_pending = 1'b0;
                end
            end
        end
    end

    // Bus slave: checks the request on its first cycle and acks after ack_delay cycles.
    initial begin : bus_slave
        int    cnt;
        bexp_t cur;
        cnt = 0;
        cur = '{32'd0, 32'd0, 4'd0, 1'b0};
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst || !bus_if.bus_req) begin
                bus_if.bus_ack = 1'b0;
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    if (bq.size() == 0) begin
                        check("unexpected_bus_req", 32'd1, 32'd0);
                    end else begin
                        cur = bq.pop_front();
                        check("bus_addr", bus_if.bus_addr, cur.addr);
                        check("bus_be", {28'd0, bus_if.bus_be}, {28'd0, cur.be});
                        check("bus_we", {31'd0, bus_if.bus_we}, {31'd0, cur.we});
                        check("bus_wdata", bus_if.bus_wdata, cur.wdata);
                    end
                end else begin
                    check("bus_addr_stable", bus_if.bus_addr, cur.addr);
                    check("bus_be_stable", {28'd0, bus_if.bus_be}, {28'd0, cur.be});
                end
                if (cnt == ack_delay) begin
                    bus_if.bus_ack   = 1'b1;
                    bus_if.bus_rdata = resp_data;
                end else begin
                    bus_if.bus_ack = 1'b0;
                end
                cnt++;
            end
        end
    end

    task automatic issue(
        input logic [31:0] addr, input logic [31:0] wdat, input logic [31:0] rdata,
        input logic width, input logic sext, input logic rw, input logic en,
        input logic src, input logic wreg, input int delay,
        input logic [31:0] e_data, input logic e_reg, input logic e_fault, input int e_stalls,
        input logic has_bus, input logic [31:0] b_addr, input logic [31:0] b_wdata,
        input logic [3:0] b_be, input int flush_cycle, input logic flush_now
    );
        logic done;
        alu_res_in     = addr;
        mem_write_in   = wdat;
        mem_width_in   = width;
        sign_extend_in = sext;
        mem_rw_in      = rw;
        mem_enable_in  = en;
        wb_src_in      = src;
        wb_reg_in      = wreg;
        flush          = flush_now;
        resp_data      = rdata;
        ack_delay      = delay;
        sb.push_back('{e_data, e_reg, e_fault, e_stalls});
        if (has_bus) bq.push_back('{b_addr, b_wdata, b_be, rw});
        issue_pending = 1'b1;
        done = 1'b0;
        for (int cyc = 1; cyc <= 2000 && !done; cyc++) begin
            @(posedge clk);
            if (!issue_pending) done = 1'b1;
            else if (cyc == flush_cycle) begin #1 flush = 1'b1; end
            else if (cyc == flush_cycle + 1) begin #1 flush = 1'b0; end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: addr 0x%08h got no result, required one within 2000 cycles", addr);
            issue_pending = 1'b0;
            sb.delete();
        end
        #1;
        flush         = 1'b0;
        mem_enable_in = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst = 1'b1;
        flush = 1'b0;
        pc_in = 32'h0000_1000;
        inst_in = 32'h00A0_0093;
        alu_res_in = 32'h0;
        mem_write_in = 32'h0;
        mem_width_in = 1'b0;
        sign_extend_in = 1'b0;
        mem_rw_in = 1'b0;
        mem_enable_in = 1'b1;
        wb_src_in = 1'b0;
        wb_reg_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
        check("rst_stall_req", {31'd0, stall_req}, 32'd0);
        check("rst_fault_out", {31'd0, fault_out}, 32'd0);
        check("rst_wb_reg_out", {31'd0, wb_reg_out}, 32'd0);
        mem_enable_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // ALU op passes straight through
        issue(32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234, 1, 0, 0, 0, 0, 0, 0, -1, 0);
        check("pc_out", pc_out, 32'h0000_1000);
        check("inst_out", inst_out, 32'h00A0_0093);
        // word load, 3 WAIT cycles
        issue(32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 1, 1, 1, 3, 32'hDEADBEEF, 1, 0, 4, 1, 32'h100, 32'h0, 4'b1111, -1, 0);
        // signed byte load lane 3, ack in IDLE
        issue(32'h103, 0, 32'h80FFFFFF, 1, 1, 0, 1, 1, 1, 0, 32'hFFFFFF80, 1, 0, 1, 1, 32'h100, 32'h0, 4'b1000, -1, 0);
        issue(32'h103, 0, 32'h80FFFFFF, 1, 0, 0, 1, 1, 1, 0, 32'h00000080, 1, 0, 1, 1, 32'h100, 32'h0, 4'b1000, -1, 0);
        // byte store lane 1
        issue(32'h201, 32'h000000A5, 0, 1, 0, 1, 1, 0, 0, 1, 32'h201, 0, 0, 2, 1, 32'h200, 32'hA5A5A5A5, 4'b0010, -1, 0);
        // misaligned word store aligns down
        issue(32'h302, 32'h11223344, 0, 0, 0, 1, 1, 0, 0, 0, 32'h302, 0, 0, 1, 1, 32'h300, 32'h11223344, 4'b1111, -1, 0);
        // zero-extended byte load lane 1, signed lane 2
        issue(32'h401, 0, 32'h12345678, 1, 0, 0, 1, 1, 1, 2, 32'h00000056, 1, 0, 3, 1, 32'h400, 32'h0, 4'b0010, -1, 0);
        issue(32'h402, 0, 32'h00A50000, 1, 1, 0, 1, 1, 1, 0, 32'hFFFFFFA5, 1, 0, 1, 1, 32'h400, 32'h0, 4'b0100, -1, 0);
        // flush in IDLE: no request, no writeback
        issue(32'h500, 0, 0, 0, 0, 0, 1, 1, 1, 0, 32'h500, 0, 0, 0, 0, 0, 0, 0, -1, 1);
        // flush in WAIT: transaction completes, writeback killed
        issue(32'h600, 0, 32'hCAFEF00D, 0, 0, 0, 1, 1, 1, 3, 32'hCAFEF00D, 0, 0, 4, 1, 32'h600, 32'h0, 4'b1111, 1, 0);
        // flush_q cleared: next writeback enabled
        issue(32'hABCD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hABCD, 1, 0, 0, 0, 0, 0, 0, -1, 0);
        // wb_src=1 without access selects ALU result
        issue(32'h77, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 1, 0, 32'h77, 1, 0, 0, 0, 0, 0, 0, -1, 0);

        // reset in the middle of WAIT
        alu_res_in = 32'h800;
        mem_write_in = 32'h0;
        mem_width_in = 1'b0;
        mem_rw_in = 1'b0;
        wb_src_in = 1'b1;
        ack_delay = 100;
        bq.push_back('{32'h800, 32'h0, 4'b1111, 1'b0});
        mem_enable_in = 1'b1;
        repeat (2) @(posedge clk);
        check("wait_stall_req", {31'd0, stall_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
        check("midrst_stall_req", {31'd0, stall_req}, 32'd0);
        mem_enable_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        issue(32'h99, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h99, 1, 0, 0, 0, 0, 0, 0, -1, 0);

`ifdef MEM_TIMEOUT_EN
        // no ack: fault after 4 WAIT cycles
        issue(32'h700, 0, 32'h5555AAAA, 0, 0, 0, 1, 1, 1, 1000, 32'h0, 0, 1, 5, 1, 32'h700, 32'h0, 4'b1111, -1, 0);
        issue(32'h88, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h88, 1, 0, 0, 0, 0, 0, 0, -1, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 32'd0);
        check("bus_q_drained", bq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_mem_access.md
Name: pipeline_mem_access

Overview:
- Memory-access stage. Sits directly downstream of the execution-to-memory pipeline register and upstream of the memory-to-writeback register.
- Consumes the registered control and data of the instruction in the MEM stage: address, store data, width, sign extension, read/write, enable, writeback source and writeback enable.
- Runs a req/ack data-bus transaction. Holds the pipeline via stall_req until the transaction completes. Formats load data and selects the writeback value.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; fixed 4 byte lanes.
- TIMEOUT_CYCLES, 255, WAIT cycles before a bus fault; only used with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill current MEM instruction.
- pc_in  in  ADDR_WIDTH  PC of MEM instruction.
- inst_in  in  DATA_WIDTH  instruction word.
- alu_res_in  in  DATA_WIDTH  ALU result / effective address.
- mem_width_in  in  1  0 = word, 1 = byte.
- sign_extend_in  in  1  1 = sign-extend byte loads.
- mem_rw_in  in  1  1 = store, 0 = load.
- mem_enable_in  in  1  instruction accesses memory.
- mem_write_in  in  DATA_WIDTH  store data.
- wb_src_in  in  1  0 = ALU result, 1 = load data.
- wb_reg_in  in  1  instruction writes a register.
- pc_out  out  ADDR_WIDTH  = pc_in.
- inst_out  out  DATA_WIDTH  = inst_in.
- wb_data_out  out  DATA_WIDTH  writeback value.
- wb_reg_out  out  1  writeback enable after flush masking.
- stall_req  out  1  hold all upstream pipeline registers.
- fault_out  out  1  bus timeout fault, one cycle in DONE.
- bus_req  out  1  transaction request.
- bus_we  out  1  write strobe.
- bus_addr  out  ADDR_WIDTH  word-aligned address {alu_res_in[ADDR_WIDTH-1:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  DATA_WIDTH  store data.
- bus_rdata  in  DATA_WIDTH  read data, valid with bus_ack.
- bus_ack  in  1  completes a transaction.

Behaviour:
- Reset:
  - state=IDLE; rdata_q=0; flush_q=0; timeout counter=0.
  - Combinational outputs forced to 0 while rst is high: bus_req, stall_req, fault_out, wb_reg_out.
- FSM states IDLE, WAIT, DONE:
  - IDLE:
    - start = mem_enable_in & !flush.
    - bus_req=start; stall_req=start.
    - start & bus_ack → DONE, rdata_q<=bus_rdata.
    - start & !bus_ack → WAIT.
    - Otherwise stay IDLE.
  - WAIT:
    - bus_req=1; stall_req=1.
    - Address, we, be and wdata stay stable; upstream is stalled, so the inputs hold.
    - bus_ack → DONE, rdata_q<=bus_rdata.
  - DONE:
    - bus_req=0; stall_req=0, so upstream advances at the end of this cycle.
    - Outputs present the result; → IDLE unconditionally.
    - A back-to-back memory instruction starts in the next IDLE cycle.
- Latency:
  - Every memory instruction costs at least 1 stall cycle (ack in IDLE) plus 1 cycle per WAIT cycle.
  - Non-memory instructions pass through with 0 stall.
- Byte lanes, little-endian, lane = alu_res_in[1:0]:
  - Word access: bus_be=4'b1111; bus_wdata=mem_write_in.
  - Byte access: bus_be=4'b0001<<lane; bus_wdata = mem_write_in[7:0] replicated 4 times.
  - Misaligned word address: low bits are ignored (address aligned down); no trap.
- bus_we = mem_rw_in whenever bus_req=1.
- Load formatting:
  - Word load: rdata_q.
  - Byte load: rdata_q lane byte, sign- or zero-extended per sign_extend_in.
- Writeback value:
  - wb_data_out = wb_src_in ? formatted load : alu_res_in.
  - In IDLE with wb_src_in=1 and no access, wb_data_out = alu_res_in.
- Flush:
  - Flush in IDLE: no request; wb_reg_out=0.
  - Flush in WAIT: flush_q<=1; the transaction still completes (never abandoned).
  - In DONE, wb_reg_out=0 if flush_q | flush; flush_q clears on leaving DONE.
  - Otherwise wb_reg_out=wb_reg_in.
- Reset mid-transaction: immediate return to IDLE; bus_req drops asynchronously; the bus must tolerate an aborted request.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - The counter increments each WAIT cycle.
  - At TIMEOUT_CYCLES without ack → DONE with rdata_q=0 and fault_out=1 for that cycle; wb_reg_out=0.
  - The counter clears on entering WAIT.
- Undefined: no counter; WAIT waits indefinitely; fault_out tied 0.

Decomposition:
- Shared pipeline package:
  - FSM state encoding (2 bits).
  - Width codes MEM_WORD=0, MEM_BYTE=1.
  - Byte-lane count 4.
- Sub-module mem_load_format: combinational lane select plus sign/zero extend. Shared with future halfword support.

Test Plan:
- Word load, addr 0x100, ack after 3 WAIT cycles, rdata 0xDEADBEEF → stall_req high 4 cycles, bus_be=1111, wb_data_out=0xDEADBEEF in DONE, wb_reg_out=1.
- Signed byte load, addr 0x103, rdata 0x80FFFFFF, ack in IDLE → bus_be=1000, wb_data_out=0xFFFFFF80, exactly 1 stall cycle. With sign_extend_in=0 → 0x00000080.
- Byte store, addr 0x201, data 0x000000A5 → bus_we=1, bus_be=0010, bus_wdata=0xA5A5A5A5, bus_addr=0x200.
- ALU op, wb_src_in=0, alu_res_in=0x1234, mem_enable_in=0 → no bus_req, stall_req=0, wb_data_out=0x1234.
- Flush asserted during WAIT, then ack → transaction completes, wb_reg_out=0 in DONE, next IDLE has flush_q=0. Also assert rst during WAIT → bus_req=0 same cycle, state IDLE.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack → DONE after 4 WAIT cycles, fault_out=1 for one cycle, wb_data_out=0 on load, wb_reg_out=0.
